// File: rtl/demosaic_frame_ctrl_pkg.sv
// Shared types and constants for the demosaic frame sequencer.
package demosaic_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_ACTIVE,
      ST_SKIP,
      ST_DRAIN,
      ST_DP_RST
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_LINE  = 2'd1;
   localparam logic [1:0] ERR_SHORT = 2'd2;
   localparam logic [1:0] ERR_OVF   = 2'd3;

   localparam int DP_RST_CYC = 2;

endpackage

// File: rtl/demosaic_frame_ctrl_if.sv
// DVP input stream plus demosaic-side byte/handshake bundle.
interface demosaic_frame_ctrl_if;
   logic       cam_vsync;
   logic       cam_href;
   logic [7:0] cam_data;
   logic       cam_valid;
   logic [7:0] raw_data;
   logic       data_valid;
   logic       bayer_ready;
   logic       bayer_en;
   logic       dp_rst_n;
   logic       pix_valid;

   modport master (
      input  cam_vsync, cam_href, cam_data, cam_valid, bayer_ready, pix_valid,
      output raw_data, data_valid, bayer_en, dp_rst_n
   );

   modport slave (
      output cam_vsync, cam_href, cam_data, cam_valid, bayer_ready, pix_valid,
      input  raw_data, data_valid, bayer_en, dp_rst_n
   );
endinterface

// File: rtl/demosaic_frame_ctrl_edge_det.sv
// Edge detector for DVP sync lines; pulses are valid in the cycle the new level first appears.
module dvp_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   input  logic href,
   output logic vs_rise,
   output logic vs_fall,
   output logic hr_fall
);

   logic vs_q;
   logic hr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q <= 1'b0;
         hr_q <= 1'b0;
      end else begin
         vs_q <= vsync;
         hr_q <= href;
      end
   end

   assign vs_rise = vsync & ~vs_q;
   assign vs_fall = ~vsync & vs_q;
   assign hr_fall = ~href & hr_q;

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// Frame sequencer between the DVP byte stream and the demosaic datapath.
// Optional statistics counters are built when DEMOSAIC_CTRL_STATS_EN is defined.
module demosaic_frame_ctrl
   import demosaic_ctrl_pkg::*;
#(
   parameter int IM_X     = 1280,
   parameter int IM_Y     = 720,
   parameter int SKIP_W   = 4,
   parameter int DRAIN_TO = 4096
) (
   input  logic              clk,
   input  logic              rst,
   demosaic_frame_ctrl_if.master bus,
   input  logic              cfg_enable,
   input  logic [SKIP_W-1:0] cfg_skip,
   output logic              frame_start,
   output logic              frame_done,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       err_cnt
);

   localparam int CW = $clog2(IM_X + 1);
   localparam int RW = $clog2(IM_Y + 1);
   localparam int DW = $clog2(DRAIN_TO + 1);

   state_t            state;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              line_long;
   logic              first_byte;
   logic [DW-1:0]     idle_cnt;
   logic [SKIP_W-1:0] skip_cnt;
   logic [1:0]        rst_cnt;
   logic              en_q;
   logic [7:0]        raw_data;
   logic              data_valid;
   logic              bayer_en;
   logic              dp_rst_n;
   logic              vs_rise, vs_fall, hr_fall;
   logic              fwd;
   logic [1:0]        fault;

   dvp_edge_det u_edge (
      .clk     (clk),
      .rst     (rst),
      .vsync   (bus.cam_vsync),
      .href    (bus.cam_href),
      .vs_rise (vs_rise),
      .vs_fall (vs_fall),
      .hr_fall (hr_fall)
   );

   assign fwd = bus.cam_valid & bus.cam_href;

   // Priority: vsync rise beats a simultaneous href fall; bytes past line end are not overflow.
   always_comb begin
      fault = ERR_NONE;
      if (state == ST_ACTIVE) begin
         if (vs_rise)
            fault = ERR_SHORT;
         else if (hr_fall && (col != CW'(IM_X) || line_long))
            fault = ERR_LINE;
         else if (fwd && col != CW'(IM_X) && !bus.bayer_ready)
            fault = ERR_OVF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         col         <= '0;
         row         <= '0;
         line_long   <= 1'b0;
         first_byte  <= 1'b0;
         idle_cnt    <= '0;
         skip_cnt    <= '0;
         rst_cnt     <= '0;
         en_q        <= 1'b0;
         raw_data    <= '0;
         data_valid  <= 1'b0;
         bayer_en    <= 1'b0;
         dp_rst_n    <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
         busy        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         data_valid  <= 1'b0;
         en_q        <= cfg_enable;
         case (state)
            ST_IDLE: begin
               skip_cnt <= '0;
               if (cfg_enable && !en_q) begin
                  state    <= ST_DP_RST;
                  dp_rst_n <= 1'b0;
                  rst_cnt  <= '0;
                  busy     <= 1'b1;
               end
            end
            ST_DP_RST: begin
               if (rst_cnt == 2'(DP_RST_CYC - 1)) begin
                  state    <= ST_WAIT_VS;
                  dp_rst_n <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            ST_WAIT_VS, ST_SKIP: begin
               if (!cfg_enable) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (vs_fall) begin
                  if (skip_cnt == '0) begin
                     state      <= ST_ACTIVE;
                     bayer_en   <= 1'b1;
                     skip_cnt   <= cfg_skip;
                     col        <= '0;
                     row        <= '0;
                     line_long  <= 1'b0;
                     first_byte <= 1'b1;
                  end else begin
                     state    <= ST_SKIP;
                     skip_cnt <= skip_cnt - 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (fault != ERR_NONE) begin
                  frame_err <= 1'b1;
                  err_code  <= fault;
                  bayer_en  <= 1'b0;
                  dp_rst_n  <= 1'b0;
                  rst_cnt   <= '0;
                  state     <= ST_DP_RST;
               end else if (hr_fall) begin
                  col <= '0;
                  row <= row + 1'b1;
                  if (row == RW'(IM_Y - 1)) begin
                     state    <= ST_DRAIN;
                     idle_cnt <= '0;
                  end
               end else if (fwd) begin
                  if (col == CW'(IM_X)) begin
                     line_long <= 1'b1;
                  end else begin
                     raw_data    <= bus.cam_data;
                     data_valid  <= 1'b1;
                     col         <= col + 1'b1;
                     frame_start <= first_byte;
                     first_byte  <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.pix_valid) begin
                  idle_cnt <= '0;
               end else if (idle_cnt == DW'(DRAIN_TO - 1)) begin
                  frame_done <= 1'b1;
                  bayer_en   <= 1'b0;
                  if (cfg_enable) begin
                     state <= ST_WAIT_VS;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.raw_data   = raw_data;
   assign bus.data_valid = data_valid;
   assign bus.bayer_en   = bayer_en;
   assign bus.dp_rst_n   = dp_rst_n;

`ifdef DEMOSAIC_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_done && frame_cnt != '1)
            frame_cnt <= frame_cnt + 1'b1;
         if (frame_err && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign frame_cnt = '0;
   assign err_cnt   = '0;
`endif

endmodule
